// File: rtl/mc_control_fsm_if.sv
// ---------------------------------------------------------------------------
// mc_control_fsm_if
//
// Memory request/ready handshake between the multi-cycle control FSM and the
// shared instruction/data memory.
//
// Signals:
//   mem_req    request valid (driven by the controller)
//   mem_write  request is a store (driven by the controller)
//   mem_ready  memory completes the current request this cycle (driven by memory)
//
// Modports:
//   master  the controller side (drives mem_req/mem_write, samples mem_ready)
//   slave   the memory side
// ---------------------------------------------------------------------------
interface mc_control_fsm_if;
    logic mem_req;
    logic mem_write;
    logic mem_ready;

    modport master (
        output mem_req,
        output mem_write,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_write,
        output mem_ready
    );
endinterface

// File: rtl/mc_control_fsm.sv
// ---------------------------------------------------------------------------
// mc_control_fsm
//
// Multi-cycle RV32I control FSM for a shared-memory datapath. Decodes the
// instruction register fields and comparator flags into datapath enables and
// mux selects, handles a variable-latency memory handshake with a timeout
// trap, traps on illegal instructions and counts retired instructions.
//
// Parameters:
//   CNT_W        width of retired_count
//   TIMEOUT_W    width of the memory wait counter
//   TIMEOUT_MAX  wait cycles without mem_ready before the timeout trap
//                (must be >= 1 and < 2**TIMEOUT_W)
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   mem               memory handshake (master modport: mem_req, mem_write out;
//                     mem_ready in)
//   opcode/funct3/funct7  IR[6:0], IR[14:12], IR[31:25]
//   zero, lt, ltu     ALU zero flag, signed and unsigned rs1 < rs2
//   adr_src           0 = PC, 1 = ALUOut as memory address
//   ir_write          latch IR and OldPC
//   pc_write          PC write enable
//   reg_write         register file write enable
//   result_src        00 ALUOut, 01 mem data, 10 ALU result
//   alu_src_a         00 rs1, 01 OldPC, 10 PC, 11 zero
//   alu_src_b         00 rs2, 01 imm, 10 const 4
//   alu_control       ALU operation (see ALU_* encodings)
//   imm_src           000 I, 001 S, 010 B, 011 J, 100 U
//   illegal           sticky illegal-instruction trap flag
//   mem_timeout       sticky memory-timeout trap flag
//   retired_count     instructions retired (wraps)
//
// Build option:
//   MC_CTRL_RETIRE_CNT_EN  when defined the retired-instruction counter is
//                          built; otherwise retired_count is tied to 0.
// ---------------------------------------------------------------------------
module mc_control_fsm #(
    parameter int CNT_W       = 32,
    parameter int TIMEOUT_W   = 8,
    parameter int TIMEOUT_MAX = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    mc_control_fsm_if.master     mem,
    input  logic [6:0]           opcode,
    input  logic [2:0]           funct3,
    input  logic [6:0]           funct7,
    input  logic                 zero,
    input  logic                 lt,
    input  logic                 ltu,
    output logic                 adr_src,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic                 reg_write,
    output logic [1:0]           result_src,
    output logic [1:0]           alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [3:0]           alu_control,
    output logic [2:0]           imm_src,
    output logic                 illegal,
    output logic                 mem_timeout,
    output logic [CNT_W-1:0]     retired_count
);

    typedef enum logic [4:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_MEM_ADR,
        S_MEM_READ,
        S_MEM_WB,
        S_MEM_WRITE,
        S_EXEC_R,
        S_EXEC_I,
        S_ALU_WB,
        S_LUI,
        S_AUIPC,
        S_JAL,
        S_JALR,
        S_JALR_WB,
        S_BRANCH,
        S_TRAP
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    // Value of the wait counter during the last tolerated wait cycle: if
    // mem_ready is still low then, the increment would reach TIMEOUT_MAX.
    localparam logic [TIMEOUT_W-1:0] WAIT_LAST = TIMEOUT_W'(TIMEOUT_MAX - 1);

    state_t                 state;
    state_t                 state_next;
    logic [TIMEOUT_W-1:0]   wait_cnt;
    logic                   mem_req_c;
    logic                   mem_write_c;
    logic                   set_illegal;
    logic                   set_timeout;
    logic [3:0]             alu_op_r;
    logic [3:0]             alu_op_i;
    logic                   branch_taken;
    logic                   unused_funct7_bits;

    // Only funct7[5] selects an ALU variant; the other bits are don't-care.
    assign unused_funct7_bits = ^{funct7[6], funct7[4:0]};

    assign mem.mem_req   = mem_req_c;
    assign mem.mem_write = mem_write_c;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ALU operation from funct3/funct7. The I-type form never subtracts,
    // because funct7 is part of the immediate for ADDI.
    always_comb begin
        alu_op_r = ALU_ADD;
        alu_op_i = ALU_ADD;
        case (funct3)
            3'b000: begin
                alu_op_r = funct7[5] ? ALU_SUB : ALU_ADD;
                alu_op_i = ALU_ADD;
            end
            3'b001: begin
                alu_op_r = ALU_SLL;
                alu_op_i = ALU_SLL;
            end
            3'b010: begin
                alu_op_r = ALU_SLT;
                alu_op_i = ALU_SLT;
            end
            3'b011: begin
                alu_op_r = ALU_SLTU;
                alu_op_i = ALU_SLTU;
            end
            3'b100: begin
                alu_op_r = ALU_XOR;
                alu_op_i = ALU_XOR;
            end
            3'b101: begin
                alu_op_r = funct7[5] ? ALU_SRA : ALU_SRL;
                alu_op_i = funct7[5] ? ALU_SRA : ALU_SRL;
            end
            3'b110: begin
                alu_op_r = ALU_OR;
                alu_op_i = ALU_OR;
            end
            default: begin
                alu_op_r = ALU_AND;
                alu_op_i = ALU_AND;
            end
        endcase
    end

    // Branch condition from the comparator flags of the rs1 - rs2 compare.
    always_comb begin
        branch_taken = 1'b0;
        case (funct3)
            3'b000:  branch_taken = zero;
            3'b001:  branch_taken = !zero;
            3'b100:  branch_taken = lt;
            3'b101:  branch_taken = !lt;
            3'b110:  branch_taken = ltu;
            3'b111:  branch_taken = !ltu;
            default: branch_taken = 1'b0;
        endcase
    end

    // Next-state and output decode. Everything is Moore from state except the
    // write enables that depend on mem_ready or the branch condition.
    always_comb begin
        state_next  = state;
        mem_req_c   = 1'b0;
        mem_write_c = 1'b0;
        adr_src     = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        reg_write   = 1'b0;
        result_src  = 2'b00;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        alu_control = ALU_ADD;
        imm_src     = IMM_I;
        set_illegal = 1'b0;
        set_timeout = 1'b0;

        case (state)
            S_IDLE: begin
                state_next = S_FETCH;
            end

            S_FETCH: begin
                mem_req_c  = 1'b1;
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                if (mem.mem_ready) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    state_next = S_DECODE;
                end else if (wait_cnt == WAIT_LAST) begin
                    set_timeout = 1'b1;
                    state_next  = S_TRAP;
                end
            end

            S_DECODE: begin
                // OldPC + imm lands in ALUOut so a branch or JAL has its
                // target ready on the following cycle.
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (opcode)
                    OP_BRANCH: imm_src = IMM_B;
                    OP_JAL:    imm_src = IMM_J;
                    default:   imm_src = IMM_I;
                endcase
                case (opcode)
                    OP_LOAD, OP_STORE: state_next = S_MEM_ADR;
                    OP_R:              state_next = S_EXEC_R;
                    OP_I:              state_next = S_EXEC_I;
                    OP_JAL:            state_next = S_JAL;
                    OP_LUI:            state_next = S_LUI;
                    OP_AUIPC:          state_next = S_AUIPC;
                    OP_JALR: begin
                        if (funct3 == 3'b000) begin
                            state_next = S_JALR;
                        end else begin
                            set_illegal = 1'b1;
                            state_next  = S_TRAP;
                        end
                    end
                    OP_BRANCH: begin
                        // funct3 010/011 are unassigned branch encodings.
                        if (funct3[2:1] != 2'b01) begin
                            state_next = S_BRANCH;
                        end else begin
                            set_illegal = 1'b1;
                            state_next  = S_TRAP;
                        end
                    end
                    default: begin
                        set_illegal = 1'b1;
                        state_next  = S_TRAP;
                    end
                endcase
            end

            S_MEM_ADR: begin
                alu_src_b  = 2'b01;
                imm_src    = opcode[5] ? IMM_S : IMM_I;
                state_next = opcode[5] ? S_MEM_WRITE : S_MEM_READ;
            end

            S_MEM_READ: begin
                mem_req_c = 1'b1;
                adr_src   = 1'b1;
                if (mem.mem_ready) begin
                    state_next = S_MEM_WB;
                end else if (wait_cnt == WAIT_LAST) begin
                    set_timeout = 1'b1;
                    state_next  = S_TRAP;
                end
            end

            S_MEM_WB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                state_next = S_FETCH;
            end

            S_MEM_WRITE: begin
                mem_req_c   = 1'b1;
                mem_write_c = 1'b1;
                adr_src     = 1'b1;
                if (mem.mem_ready) begin
                    state_next = S_FETCH;
                end else if (wait_cnt == WAIT_LAST) begin
                    set_timeout = 1'b1;
                    state_next  = S_TRAP;
                end
            end

            S_EXEC_R: begin
                alu_control = alu_op_r;
                state_next  = S_ALU_WB;
            end

            S_EXEC_I: begin
                alu_src_b   = 2'b01;
                alu_control = alu_op_i;
                state_next  = S_ALU_WB;
            end

            S_ALU_WB: begin
                reg_write  = 1'b1;
                state_next = S_FETCH;
            end

            S_LUI: begin
                alu_src_a  = 2'b11;
                alu_src_b  = 2'b01;
                imm_src    = IMM_U;
                state_next = S_ALU_WB;
            end

            S_AUIPC: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b01;
                imm_src    = IMM_U;
                state_next = S_ALU_WB;
            end

            S_JAL: begin
                // PC takes the target from ALUOut while the ALU forms the
                // link address OldPC + 4 for the write-back cycle.
                pc_write   = 1'b1;
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                state_next = S_ALU_WB;
            end

            S_JALR: begin
                alu_src_b  = 2'b01;
                state_next = S_JALR_WB;
            end

            S_JALR_WB: begin
                pc_write   = 1'b1;
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                state_next = S_ALU_WB;
            end

            S_BRANCH: begin
                alu_control = ALU_SUB;
                imm_src     = IMM_B;
                pc_write    = branch_taken;
                state_next  = S_FETCH;
            end

            S_TRAP: begin
                state_next = S_TRAP;
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Memory wait counter: counts consecutive unanswered request cycles and
    // restarts whenever the FSM is not holding in a wait state, so each new
    // wait state begins from zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (mem_req_c && !mem.mem_ready && (state_next == state)) begin
            wait_cnt <= wait_cnt + TIMEOUT_W'(1);
        end else begin
            wait_cnt <= '0;
        end
    end

    // Sticky trap flags, cleared only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            illegal     <= 1'b0;
            mem_timeout <= 1'b0;
        end else begin
            if (set_illegal) begin
                illegal <= 1'b1;
            end
            if (set_timeout) begin
                mem_timeout <= 1'b1;
            end
        end
    end

`ifdef MC_CTRL_RETIRE_CNT_EN
    logic [CNT_W-1:0] retired_q;

    // An instruction retires when the FSM returns to FETCH from any
    // instruction state; the initial IDLE -> FETCH step and FETCH holding
    // for memory are not retirements.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retired_q <= '0;
        end else if ((state_next == S_FETCH) && (state != S_IDLE) &&
                     (state != S_FETCH) && (state != S_TRAP)) begin
            retired_q <= retired_q + CNT_W'(1);
        end
    end

    assign retired_count = retired_q;
`else
    assign retired_count = '0;
`endif

endmodule

// File: tb/tb_mc_control_fsm.sv
// ---------------------------------------------------------------------------
// tb_mc_control_fsm
//
// Directed bench for mc_control_fsm built with CNT_W=4 and TIMEOUT_MAX=4 so
// counter wrap and memory timeout are reachable in a few cycles. Expected
// values are hand-derived constants; retired_count is expected to be 0 unless
// MC_CTRL_RETIRE_CNT_EN is defined.
// ---------------------------------------------------------------------------
module tb_mc_control_fsm;

    localparam int CNT_W       = 4;
    localparam int TIMEOUT_W   = 8;
    localparam int TIMEOUT_MAX = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic [6:0]       funct7;
    logic             zero;
    logic             lt;
    logic             ltu;
    logic             adr_src;
    logic             ir_write;
    logic             pc_write;
    logic             reg_write;
    logic [1:0]       result_src;
    logic [1:0]       alu_src_a;
    logic [1:0]       alu_src_b;
    logic [3:0]       alu_control;
    logic [2:0]       imm_src;
    logic             illegal;
    logic             mem_timeout;
    logic [CNT_W-1:0] retired_count;

    int checks_total = 0;
    int checks_passed = 0;
    int exp_retired = 0;

    mc_control_fsm_if mem ();

    mc_control_fsm #(
        .CNT_W       (CNT_W),
        .TIMEOUT_W   (TIMEOUT_W),
        .TIMEOUT_MAX (TIMEOUT_MAX)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .mem           (mem),
        .opcode        (opcode),
        .funct3        (funct3),
        .funct7        (funct7),
        .zero          (zero),
        .lt            (lt),
        .ltu           (ltu),
        .adr_src       (adr_src),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .reg_write     (reg_write),
        .result_src    (result_src),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_control   (alu_control),
        .imm_src       (imm_src),
        .illegal       (illegal),
        .mem_timeout   (mem_timeout),
        .retired_count (retired_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [6:0] op, input logic [2:0] f3,
                                 input logic [6:0] f7, input logic z,
                                 input logic l, input logic lu, input logic rdy);
        opcode        = op;
        funct3        = f3;
        funct7        = f7;
        zero          = z;
        lt            = l;
        ltu           = lu;
        mem.mem_ready = rdy;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks_total = checks_total + 1;
        assert (observed === expected) checks_passed = checks_passed + 1;
        else $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    endtask

    function automatic logic [31:0] expRetired();
`ifdef MC_CTRL_RETIRE_CNT_EN
        return 32'(exp_retired % (1 << CNT_W));
`else
        return 32'd0;
`endif
    endfunction

    task automatic doReset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_retired = 0;
    endtask

    // Expects to be in FETCH with mem_ready=1; checks the fetch controls and
    // steps into DECODE.
    task automatic checkFetch(input string tag);
        checkOutput(tag, 32'({mem.mem_req, mem.mem_write, adr_src, alu_src_a, alu_src_b,
                              alu_control, result_src, ir_write, pc_write, reg_write}),
                    32'({1'b1, 1'b0, 1'b0, 2'b10, 2'b10, 4'b0000, 2'b10, 1'b1, 1'b1, 1'b0}));
        tick();
    endtask

    // From FETCH: run one branch and return to FETCH.
    task automatic runBranch(input string tag, input logic [2:0] f3, input logic z,
                             input logic l, input logic lu, input logic exp_pc);
        applyStimulus(7'b1100011, f3, 7'b0000000, z, l, lu, 1'b1);
        tick();
        tick();
        checkOutput(tag, 32'({pc_write, alu_control, result_src, alu_src_a, alu_src_b,
                              mem.mem_req}),
                    32'({exp_pc, 4'b0001, 2'b00, 2'b00, 2'b00, 1'b0}));
        tick();
        exp_retired = exp_retired + 1;
    endtask

    // From FETCH: run one R/I ALU instruction and return to FETCH.
    task automatic runAlu(input string tag, input logic [6:0] op, input logic [2:0] f3,
                          input logic [6:0] f7, input logic [3:0] exp_alu);
        applyStimulus(op, f3, f7, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        tick();
        checkOutput(tag, 32'(alu_control), 32'(exp_alu));
        tick();
        tick();
        exp_retired = exp_retired + 1;
    endtask

    initial begin
        $display("[TB] mc_control_fsm directed test start");
        reset = 1'b1;
        applyStimulus(7'b0010011, 3'b000, 7'b0100000, 1'b0, 1'b0, 1'b0, 1'b1);
        #11;

        // Reset state: IDLE drives every output low.
        checkOutput("reset_outputs", 32'({mem.mem_req, mem.mem_write, adr_src, ir_write,
                                          pc_write, reg_write, result_src, alu_src_a,
                                          alu_src_b, alu_control, imm_src}), 32'd0);
        checkOutput("reset_flags", 32'({illegal, mem_timeout}), 32'd0);
        checkOutput("reset_retired", 32'(retired_count), 32'd0);

        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        checkOutput("idle_mem_req", 32'(mem.mem_req), 32'd0);

        // ADDI x1,x0,5 with funct7 bits set: must still be ADD.
        tick();
        checkFetch("addi_fetch");
        checkOutput("addi_decode", 32'({alu_src_a, alu_src_b, alu_control, mem.mem_req}),
                    32'({2'b01, 2'b01, 4'b0000, 1'b0}));
        tick();
        checkOutput("addi_exec", 32'({alu_src_a, alu_src_b, alu_control}),
                    32'({2'b00, 2'b01, 4'b0000}));
        tick();
        checkOutput("addi_wb", 32'({reg_write, result_src, mem.mem_req, pc_write}),
                    32'({1'b1, 2'b00, 1'b0, 1'b0}));
        tick();
        exp_retired = 1;
        checkOutput("addi_retired", 32'(retired_count), expRetired());

        // LW with memory answering on the 4th MEM_READ cycle.
        applyStimulus(7'b0000011, 3'b010, 7'b0000000, 1'b0, 1'b0, 1'b0, 1'b1);
        checkFetch("lw_fetch");
        tick();
        checkOutput("lw_memadr", 32'({alu_src_a, alu_src_b, alu_control, mem.mem_req}),
                    32'({2'b00, 2'b01, 4'b0000, 1'b0}));
        applyStimulus(7'b0000011, 3'b010, 7'b0000000, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin
                applyStimulus(7'b0000011, 3'b010, 7'b0000000, 1'b0, 1'b0, 1'b0, 1'b1);
            end
            checkOutput("lw_memread", 32'({mem.mem_req, adr_src, mem.mem_write, reg_write}),
                        32'({1'b1, 1'b1, 1'b0, 1'b0}));
            tick();
        end
        checkOutput("lw_memwb", 32'({reg_write, result_src, mem.mem_req}),
                    32'({1'b1, 2'b01, 1'b0}));
        tick();
        exp_retired = 2;
        checkOutput("lw_back_fetch", 32'({mem.mem_req, reg_write}), 32'({1'b1, 1'b0}));
        checkOutput("lw_retired", 32'(retired_count), expRetired());

        // Branch set.
        runBranch("bgeu_ltu1", 3'b111, 1'b0, 1'b0, 1'b1, 1'b0);
        runBranch("blt_lt1",   3'b100, 1'b0, 1'b1, 1'b0, 1'b1);
        runBranch("bne_zero1", 3'b001, 1'b1, 1'b0, 1'b0, 1'b0);
        runBranch("beq_zero1", 3'b000, 1'b1, 1'b0, 1'b0, 1'b1);
        runBranch("bge_lt0",   3'b101, 1'b0, 1'b0, 1'b0, 1'b1);
        runBranch("bltu_ltu0", 3'b110, 1'b0, 1'b0, 1'b0, 1'b0);

        // ALU decode.
        runAlu("r_sub",  7'b0110011, 3'b000, 7'b0100000, 4'b0001);
        runAlu("r_add",  7'b0110011, 3'b000, 7'b0000000, 4'b0000);
        runAlu("i_srai", 7'b0010011, 3'b101, 7'b0100000, 4'b0111);
        runAlu("i_srli", 7'b0010011, 3'b101, 7'b0000000, 4'b0110);
        runAlu("r_sltu", 7'b0110011, 3'b011, 7'b0000000, 4'b1001);
        runAlu("i_slt",  7'b0010011, 3'b010, 7'b0000000, 4'b1000);

        // JAL.
        applyStimulus(7'b1101111, 3'b000, 7'b0000000, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        tick();
        checkOutput("jal_exec", 32'({pc_write, result_src, mem.mem_req, reg_write}),
                    32'({1'b1, 2'b00, 1'b0, 1'b0}));
        tick();
        checkOutput("jal_wb", 32'({reg_write, pc_write}), 32'({1'b1, 1'b0}));
        tick();
        exp_retired = exp_retired + 1;
        checkOutput("retired_15", 32'(retired_count), expRetired());

        // Two more retirements take the 4-bit counter past 15 to 1.
        runBranch("beq_wrap_a", 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
        runBranch("beq_wrap_b", 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("retire_wrap", 32'(retired_count), expRetired());

        // SW held in MEM_WRITE, then reset mid-cycle.
        applyStimulus(7'b0100011, 3'b010, 7'b0000000, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        tick();
        applyStimulus(7'b0100011, 3'b010, 7'b0000000, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("sw_memwrite", 32'({mem.mem_req, mem.mem_write, adr_src}), 32'(3'b111));
        tick();
        #1;
        reset = 1'b1;
        #1;
        checkOutput("sw_reset_mem_req", 32'({mem.mem_req, mem.mem_write}), 32'd0);
        checkOutput("sw_reset_idle", 32'({adr_src, ir_write, pc_write, reg_write, result_src,
                                          alu_src_a, alu_src_b, alu_control}), 32'd0);
        checkOutput("sw_reset_retired", 32'(retired_count), 32'd0);

        // Memory timeout in FETCH after four unanswered cycles.
        doReset();
        applyStimulus(7'b0010011, 3'b000, 7'b0000000, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 4; i++) begin
            checkOutput("to_wait", 32'({mem.mem_req, ir_write, mem_timeout}), 32'(3'b100));
            tick();
        end
        checkOutput("to_trap", 32'({mem.mem_req, ir_write, pc_write, mem_timeout, illegal}),
                    32'(5'b00010));
        applyStimulus(7'b0010011, 3'b000, 7'b0000000, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        checkOutput("to_absorb", 32'({mem.mem_req, ir_write, mem_timeout}), 32'(3'b001));

        // mem_ready on the 4th wait cycle wins over the timeout.
        doReset();
        checkOutput("to_reset_clear", 32'(mem_timeout), 32'd0);
        applyStimulus(7'b0010011, 3'b000, 7'b0000000, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        tick();
        tick();
        applyStimulus(7'b0010011, 3'b000, 7'b0000000, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("to_last_ready", 32'({mem.mem_req, ir_write, pc_write}), 32'(3'b111));
        tick();
        checkOutput("to_decode", 32'({alu_src_a, alu_src_b, mem.mem_req, mem_timeout}),
                    32'({2'b01, 2'b01, 1'b0, 1'b0}));

        // Illegal opcode 0000000 traps and stays trapped.
        doReset();
        applyStimulus(7'b0000000, 3'b000, 7'b0000000, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        tick();
        tick();
        for (int i = 0; i < 10; i++) begin
            applyStimulus(7'b0110011, 3'(i), 7'b0100000, i[0], i[1], i[2], i[0]);
            checkOutput("ill_trap", 32'({mem.mem_req, mem.mem_write, ir_write, pc_write,
                                         reg_write, illegal}), 32'(6'b000001));
            tick();
        end
        reset = 1'b1;
        #1;
        checkOutput("ill_reset_clear", 32'({illegal, mem_timeout}), 32'd0);

        // Branch funct3 010 is an illegal encoding.
        doReset();
        applyStimulus(7'b1100011, 3'b010, 7'b0000000, 1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        tick();
        tick();
        checkOutput("ill_branch_f3", 32'({illegal, pc_write, mem.mem_req}), 32'(3'b100));

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Next-generation multi-cycle RV32I control FSM.
- Adds a variable-latency memory request/ready handshake, the full branch set (BEQ/BNE/BLT/BGE/BLTU/BGEU), and illegal-instruction and memory-timeout traps.
- Adds a parametrised retired-instruction counter and a 4-bit ALU control with SLT/SLTU.
- Sits between the instruction register/comparator flags and the shared-memory multi-cycle datapath.

Parameters:
- CNT_W, 32, width of retired_count
- TIMEOUT_W, 8, width of memory wait counter
- TIMEOUT_MAX, 255, wait cycles without mem_ready before timeout trap; must be < 2^TIMEOUT_W

Ports:
- clk  in  1  clock
- reset  in  1  reset
- opcode  in  7  IR[6:0]
- funct3  in  3  IR[14:12]
- funct7  in  7  IR[31:25]
- zero  in  1  ALU result == 0
- lt  in  1  rs1 < rs2, signed
- ltu  in  1  rs1 < rs2, unsigned
- mem_ready  in  1  memory completes current request this cycle
- mem_req  out  1  memory request valid
- mem_write  out  1  request is a store
- adr_src  out  1  0 = PC, 1 = ALUOut as address
- ir_write  out  1  latch IR and OldPC
- pc_write  out  1  PC write enable
- reg_write  out  1  register file write enable
- result_src  out  2  00 ALUOut, 01 mem data, 10 ALU result
- alu_src_a  out  2  00 rs1, 01 OldPC, 10 PC, 11 zero
- alu_src_b  out  2  00 rs2, 01 imm, 10 const 4
- alu_control  out  4  ALU operation
- imm_src  out  3  000 I, 001 S, 010 B, 011 J, 100 U
- illegal  out  1  sticky: illegal-instruction trap taken
- mem_timeout  out  1  sticky: memory-timeout trap taken
- retired_count  out  CNT_W  instructions retired

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high (reset).
- Reset: state = IDLE, wait counter = 0, retired_count = 0, illegal = 0, mem_timeout = 0.
- Outputs are Moore-decoded from state, except ir_write, pc_write and reg_write, which may qualify on inputs. In IDLE all outputs are 0.
- IDLE -> FETCH unconditionally; one cycle after reset deassertion.
- FETCH:
  - mem_req=1, adr_src=0, alu_src_a=10, alu_src_b=10, ADD, result_src=10.
  - ir_write and pc_write are 1 only in the cycle mem_ready=1; then -> DECODE. Otherwise stay.
- DECODE: alu_src_a=01, alu_src_b=01, ADD (precomputes branch/JAL target into ALUOut). Next state by opcode:
  - load/store -> MEM_ADR
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 1101111 -> JAL
  - 1100111 with funct3=000 -> JALR
  - 1100011 with funct3 not 010/011 -> BRANCH
  - 0110111 -> LUI
  - 0010111 -> AUIPC
  - anything else -> TRAP with illegal set
- MEM_ADR: rs1 + imm; -> MEM_READ (load) or MEM_WRITE (store).
- MEM_READ: mem_req=1, adr_src=1; waits for mem_ready; -> MEM_WB.
- MEM_WB: result_src=01, reg_write=1; -> FETCH.
- MEM_WRITE: mem_req=1, mem_write=1, adr_src=1; holds until mem_ready; -> FETCH.
- EXEC_R / EXEC_I: rs1 op rs2/imm; -> ALU_WB.
- ALU_WB: result_src=00, reg_write=1; -> FETCH.
- LUI: zero + imm. AUIPC: OldPC + imm. Both -> ALU_WB.
- JAL: pc_write=1, result_src=00 (target); ALU computes OldPC+4; -> ALU_WB.
- JALR: ALU rs1 + imm; -> JALR_WB.
- JALR_WB: pc_write=1, result_src=00. Datapath clears bit0; rd gets the old PC+4, which is held in the IR-latched OldPC path via alu_src_a=01, b=10 in the next cycle. -> ALU_WB.
- BRANCH: rs1 - rs2 (SUB); result_src=00; pc_write = condition. Conditions by funct3:
  - 000 zero
  - 001 !zero
  - 100 lt
  - 101 !lt
  - 110 ltu
  - 111 !ltu
  - Then -> FETCH.
- alu_control encoding:
  - ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLL 0101, SRL 0110, SRA 0111, SLT 1000, SLTU 1001.
  - R-type funct3=000: SUB iff funct7[5].
  - I-type funct3=000: always ADD.
  - funct3=101: SRA iff funct7[5].
- Wait counter:
  - Clears on entry to any wait state.
  - Increments each cycle mem_req=1 && !mem_ready.
  - On reaching TIMEOUT_MAX -> TRAP with mem_timeout set.
  - mem_ready on the threshold cycle wins: no trap.
- TRAP: all enables 0, mem_req=0; absorbing until reset.
- Retire counter:
  - retired_count increments by 1 on every transition into FETCH from a non-IDLE, non-TRAP state.
  - Wraps from 2^CNT_W-1 to 0.
- Reset mid-operation: immediate return to IDLE. A pending mem_req drops asynchronously.

Optional Feature:
- MC_CTRL_RETIRE_CNT_EN
- Defined: retired_count behaves as above.
- Undefined: counter logic omitted; retired_count is constant 0. All other behaviour is identical.

Test Plan:
- ADDI x1,x0,5 with mem_ready=1 always -> IDLE,FETCH,DECODE,EXEC_I,ALU_WB,FETCH; alu_control=0000 in EXEC_I even with funct7=0100000; retired_count=1.
- LW with mem_ready delayed 3 cycles in MEM_READ -> mem_req held 4 cycles, adr_src=1; single reg_write in MEM_WB.
- BGEU with ltu=1 -> pc_write=0. BLT with lt=1 -> pc_write=1. BNE with zero=1 -> pc_write=0.
- Opcode 0000000 -> TRAP, illegal=1, all enables 0 for 10 further cycles; reset clears it.
- mem_ready held 0 in FETCH with TIMEOUT_MAX=4 -> TRAP after 4 wait cycles, mem_timeout=1. Repeat with mem_ready=1 on the 4th cycle -> DECODE, no trap.
- CNT_W=4, 17 retired instructions -> retired_count=1. Reset asserted mid-MEM_WRITE -> mem_req=0 same cycle, state IDLE.
